// File: rtl/io_extend_pkg.sv
// Shared constants for the io-extend SPI register bank: register map,
// write-flag position and the default ID byte.
package io_extend_pkg;

  localparam int unsigned WR_FLAG_BIT = 7;

  localparam logic [6:0] REG_ID       = 7'h00;
  localparam logic [6:0] REG_OUT      = 7'h01;
  localparam logic [6:0] REG_DIR      = 7'h02;
  localparam logic [6:0] REG_IN       = 7'h03;
  localparam logic [6:0] REG_IRQ_STAT = 7'h04;
  localparam logic [6:0] REG_IRQ_MASK = 7'h05;
  localparam logic [6:0] REG_SCRATCH  = 7'h06;

  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/gpio_input_sync.sv
// Two-flop synchroniser for asynchronous GPIO pins, with an optional third
// flop that produces a one-cycle rising-edge strobe per pin.
module gpio_input_sync #(
  parameter int unsigned GPIO_W  = 8,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [GPIO_W-1:0] i_pins,
  output logic [GPIO_W-1:0] o_sync,
  output logic [GPIO_W-1:0] o_rise
);

  logic [GPIO_W-1:0] r_s1;
  logic [GPIO_W-1:0] r_s2;

  // Metastability chain: r_s1 may go metastable, r_s2 is the usable copy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_pins;
      r_s2 <= r_s1;
    end
  end

  assign o_sync = r_s2;

  if (EDGE_EN) begin : g_edge
    logic [GPIO_W-1:0] r_s3;

    // Delayed copy of the synchronised pins for rising-edge detection.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_s3 <= '0;
      end else begin
        r_s3 <= r_s2;
      end
    end

    assign o_rise = r_s2 & ~r_s3;
  end else begin : g_no_edge
    assign o_rise = '0;
  end

endmodule

// File: rtl/spi_io_register_bank.sv
// GPIO register bank behind the SPI slave byte-pair receiver. Commits a
// transaction on each rising edge of i_spi_data_ready and returns pipelined
// read data (register selected by the previous transaction).
// Optional interrupt logic (IRQ_STAT/IRQ_MASK/o_irq) is built when the macro
// IO_IRQ_EN is defined; otherwise those addresses read 0 and o_irq is 0.
module spi_io_register_bank
  import io_extend_pkg::*;
#(
  parameter int unsigned GPIO_W   = 8,
  parameter logic [7:0]  ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_spi_address,
  input  logic [7:0]        i_spi_data,
  input  logic              i_spi_data_ready,
  input  logic              i_spi_address_ready,
  output logic [7:0]        o_spi_data_in,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic [GPIO_W-1:0] o_gpio_oe,
  output logic              o_commit,
  output logic              o_irq
);

  logic              r_dr_q;
  logic              r_commit;
  logic [6:0]        r_rd_ptr;
  logic [GPIO_W-1:0] r_out;
  logic [GPIO_W-1:0] r_dir;
  logic [7:0]        r_scratch;
  logic [7:0]        r_data_in;

  logic              w_commit;
  logic              w_wr;
  logic [6:0]        w_addr;
  logic [GPIO_W-1:0] w_wdata;
  logic [GPIO_W-1:0] w_sync;
  logic [7:0]        w_stat_rd;
  logic [7:0]        w_mask_rd;
  logic [7:0]        w_rd_data;

  assign w_commit = i_spi_data_ready & ~r_dr_q;
  assign w_wr     = w_commit & i_spi_address[WR_FLAG_BIT];
  assign w_addr   = i_spi_address[6:0];
  assign w_wdata  = i_spi_data[GPIO_W-1:0];

`ifdef IO_IRQ_EN
  localparam bit EdgeEn = 1'b1;
  logic [GPIO_W-1:0] w_rise;
`else
  localparam bit EdgeEn = 1'b0;
  logic [GPIO_W-1:0] w_unused_rise;
`endif

  gpio_input_sync #(
    .GPIO_W  (GPIO_W),
    .EDGE_EN (EdgeEn)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pins  (i_gpio_in),
    .o_sync  (w_sync),
`ifdef IO_IRQ_EN
    .o_rise  (w_rise)
`else
    .o_rise  (w_unused_rise)
`endif
  );

  // Transaction detect and writes to the plain read/write registers.
  // r_dr_q resets to 1 so an idle CS at reset release is not a rising edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dr_q    <= 1'b1;
      r_commit  <= 1'b0;
      r_rd_ptr  <= '0;
      r_out     <= '0;
      r_dir     <= '0;
      r_scratch <= '0;
    end else begin
      r_dr_q   <= i_spi_data_ready;
      r_commit <= w_commit;
      if (w_commit) begin
        r_rd_ptr <= w_addr;
      end
      if (w_wr) begin
        case (w_addr)
          REG_OUT:     r_out     <= w_wdata;
          REG_DIR:     r_dir     <= w_wdata;
          REG_SCRATCH: r_scratch <= i_spi_data;
          default:     ;
        endcase
      end
    end
  end

`ifdef IO_IRQ_EN
  logic [GPIO_W-1:0] r_irq_stat;
  logic [GPIO_W-1:0] r_irq_mask;
  logic              r_irq;
  logic [GPIO_W-1:0] w_stat_clr;

  assign w_stat_clr = (w_wr && (w_addr == REG_IRQ_STAT)) ? w_wdata : '0;

  // Interrupt status/mask; a new edge overrides a W1C of the same bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_irq_stat <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_rise;
      if (w_wr && (w_addr == REG_IRQ_MASK)) begin
        r_irq_mask <= w_wdata;
      end
      r_irq <= |(r_irq_stat & r_irq_mask);
    end
  end

  assign w_stat_rd = 8'(r_irq_stat);
  assign w_mask_rd = 8'(r_irq_mask);
  assign o_irq     = r_irq;
`else
  assign w_stat_rd = 8'h00;
  assign w_mask_rd = 8'h00;
  assign o_irq     = 1'b0;
`endif

  // Read mux addressed by the previous transaction's address.
  always_comb begin
    w_rd_data = 8'h00;
    case (r_rd_ptr)
      REG_ID:       w_rd_data = ID_VALUE;
      REG_OUT:      w_rd_data = 8'(r_out);
      REG_DIR:      w_rd_data = 8'(r_dir);
      REG_IN:       w_rd_data = 8'(w_sync);
      REG_IRQ_STAT: w_rd_data = w_stat_rd;
      REG_IRQ_MASK: w_rd_data = w_mask_rd;
      REG_SCRATCH:  w_rd_data = r_scratch;
      default:      w_rd_data = 8'h00;
    endcase
  end

  // Read data tracks the mux outside the data phase and freezes during it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data_in <= 8'h00;
    end else if (!i_spi_address_ready) begin
      r_data_in <= w_rd_data;
    end
  end

  assign o_spi_data_in = r_data_in;
  assign o_gpio_out    = r_out;
  assign o_gpio_oe     = r_dir;
  assign o_commit      = r_commit;

endmodule

// File: tb/tb_spi_io_register_bank.sv
// Self-checking bench for spi_io_register_bank: table of SPI transactions
// with expected GPIO outputs, a read-data scoreboard fed by a register model,
// and hand-written sequences for reset, data-phase hold, IRQ and back-to-back.
module tb_spi_io_register_bank;

  localparam int unsigned GPIO_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        spi_address;
  logic [7:0]        spi_data;
  logic              spi_data_ready;
  logic              spi_address_ready;
  logic [7:0]        spi_data_in;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              commit;
  logic              irq;

  spi_io_register_bank #(
    .GPIO_W   (GPIO_W),
    .ID_VALUE (8'hA5)
  ) dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_spi_address       (spi_address),
    .i_spi_data          (spi_data),
    .i_spi_data_ready    (spi_data_ready),
    .i_spi_address_ready (spi_address_ready),
    .o_spi_data_in       (spi_data_in),
    .i_gpio_in           (gpio_in),
    .o_gpio_out          (gpio_out),
    .o_gpio_oe           (gpio_oe),
    .o_commit            (commit),
    .o_irq               (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int commit_cnt = 0;

  always @(negedge clk) if (commit === 1'b1) commit_cnt++;

  // Register model
  logic [7:0] m_out, m_dir, m_scratch, m_stat, m_mask;
  logic [6:0] m_rdptr;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_scratch = 0; m_stat = 0; m_mask = 0; m_rdptr = 0;
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] p);
    case (p)
      7'h00: return 8'hA5;
      7'h01: return m_out;
      7'h02: return m_dir;
      7'h03: return gpio_in;
`ifdef IO_IRQ_EN
      7'h04: return m_stat;
      7'h05: return m_mask;
`endif
      7'h06: return m_scratch;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
    m_rdptr = a[6:0];
    if (a[7]) begin
      case (a[6:0])
        7'h01: m_out = d;
        7'h02: m_dir = d;
        7'h04: m_stat = m_stat & ~d;
        7'h05: m_mask = d;
        7'h06: m_scratch = d;
        default: ;
      endcase
    end
  endtask

  task automatic set_gpio(input logic [7:0] v);
    m_stat = m_stat | (v & ~gpio_in);
    gpio_in = v;
  endtask

  // One full SPI frame: CS active, data phase (read byte checked), CS release.
  task automatic txn(input logic [7:0] a, input logic [7:0] d, input string name);
    logic [7:0] exp;
    @(negedge clk);
    spi_data_ready = 1'b0;
    spi_address_ready = 1'b0;
    @(negedge clk);
    spi_address_ready = 1'b1;
    sb_q.push_back(model_rd(m_rdptr));
    @(negedge clk);
    exp = sb_q.pop_front();
    chk({name, " rd"}, spi_data_in, exp);
    @(negedge clk);
    chk({name, " rd hold"}, spi_data_in, exp);
    spi_address_ready = 1'b0;
    spi_address = a;
    spi_data = d;
    spi_data_ready = 1'b1;
    @(negedge clk);
    chk({name, " commit"}, {7'b0, commit}, 8'h01);
    model_wr(a, d);
    @(negedge clk);
    chk({name, " commit end"}, {7'b0, commit}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    logic [7:0] b2b_vals[3];
    vecs[0]  = '{8'h81, 8'h3C, 8'h3C, 8'h00};
    vecs[1]  = '{8'h82, 8'hF0, 8'h3C, 8'hF0};
    vecs[2]  = '{8'h00, 8'h55, 8'h3C, 8'hF0};
    vecs[3]  = '{8'h86, 8'h5A, 8'h3C, 8'hF0};
    vecs[4]  = '{8'h06, 8'h00, 8'h3C, 8'hF0};
    vecs[5]  = '{8'h01, 8'h00, 8'h3C, 8'hF0};
    vecs[6]  = '{8'h80, 8'h77, 8'h3C, 8'hF0};
    vecs[7]  = '{8'h03, 8'h00, 8'h3C, 8'hF0};
    vecs[8]  = '{8'h7F, 8'h00, 8'h3C, 8'hF0};
    vecs[9]  = '{8'h81, 8'h00, 8'h00, 8'hF0};
    vecs[10] = '{8'h02, 8'h00, 8'h00, 8'hF0};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 8'hF0};
    b2b_vals[0] = 8'h11; b2b_vals[1] = 8'h22; b2b_vals[2] = 8'h33;

    // Reset with CS idle: outputs zero, no commit after release.
    reset = 1'b1;
    spi_data_ready = 1'b1;
    spi_address_ready = 1'b0;
    spi_address = 8'h00;
    spi_data = 8'h00;
    gpio_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset data_in", spi_data_in, 8'h00);
    chk("reset gpio_out", gpio_out, 8'h00);
    chk("reset gpio_oe", gpio_oe, 8'h00);
    chk("reset commit", {7'b0, commit}, 8'h00);
    chk("reset irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    commit_cnt = 0;
    repeat (5) @(negedge clk);
    chk("no commit at release", commit_cnt[7:0], 8'h00);
    chk("id after release", spi_data_in, 8'hA5);

    set_gpio(8'hC3);
    repeat (4) @(negedge clk);

    // Table of transactions
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d gpio_out", i), gpio_out, vecs[i].exp_out);
      chk($sformatf("vec%0d gpio_oe", i), gpio_oe, vecs[i].exp_oe);
    end

    // Data byte holds while address_ready is high even if IN changes.
    txn(8'h03, 8'h00, "sel_in");
    @(negedge clk);
    spi_data_ready = 1'b0;
    @(negedge clk);
    spi_address_ready = 1'b1;
    held = model_rd(7'h03);
    set_gpio(8'h5A);
    repeat (5) @(negedge clk);
    chk("hold in data phase", spi_data_in, held);
    spi_address_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("update after phase", spi_data_in, 8'h5A);
    spi_data_ready = 1'b1;
    repeat (2) @(negedge clk);
    model_wr(spi_address, spi_data);

`ifdef IO_IRQ_EN
    set_gpio(8'h00);
    repeat (4) @(negedge clk);
    txn(8'h84, 8'hFF, "stat clr");
    txn(8'h85, 8'h01, "mask wr");
    chk("irq idle", {7'b0, irq}, 8'h00);
    set_gpio(8'h01);
    repeat (3) @(negedge clk);
    chk("irq not yet", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("irq raised", {7'b0, irq}, 8'h01);
    txn(8'h04, 8'h00, "stat sel");
    txn(8'h84, 8'h01, "stat w1c");
    chk("irq cleared", {7'b0, irq}, 8'h00);
`else
    txn(8'h85, 8'hFF, "mask wr");
    txn(8'h04, 8'h00, "stat sel");
    txn(8'h05, 8'h00, "mask sel");
    txn(8'h00, 8'h00, "after mask");
    set_gpio(8'h00);
    repeat (2) @(negedge clk);
    set_gpio(8'hFF);
    repeat (6) @(negedge clk);
    chk("irq tied low", {7'b0, irq}, 8'h00);
`endif

    // Back-to-back: one-cycle CS pulses, one commit per rising edge.
    @(negedge clk);
    commit_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      spi_address = 8'h86;
      spi_data = b2b_vals[k];
      spi_data_ready = 1'b0;
      @(negedge clk);
      spi_data_ready = 1'b1;
      @(negedge clk);
      model_wr(8'h86, b2b_vals[k]);
    end
    repeat (2) @(negedge clk);
    chk("b2b commits", commit_cnt[7:0], 8'h03);
    txn(8'h00, 8'h00, "b2b rd");

    // Reset in the middle of a frame.
    txn(8'h81, 8'hFF, "pre reset");
    chk("pre reset out", gpio_out, 8'hFF);
    @(negedge clk);
    spi_data_ready = 1'b0;
    spi_address_ready = 1'b1;
    spi_address = 8'h82;
    spi_data = 8'h11;
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out", gpio_out, 8'h00);
    spi_data_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    spi_address_ready = 1'b0;
    commit_cnt = 0;
    repeat (5) @(negedge clk);
    chk("no commit after reset", commit_cnt[7:0], 8'h00);
    chk("oe after reset", gpio_oe, 8'h00);
    chk("out after reset", gpio_out, 8'h00);
    chk("rd_ptr after reset", spi_data_in, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_io_register_bank.md
# spi_io_register_bank

Register bank downstream of the SPI slave byte-pair receiver in the io-extend design. Commits decoded write transactions to GPIO control registers and returns read data on the slave's `data_in` bus. Also synchronises GPIO inputs and produces a maskable rising-edge interrupt. Sits between the SPI slave and the board's GPIO pins.

## Interface
- `GPIO_W`, 8: number of GPIO pins, 1..8.
- `ID_VALUE`, 8'hA5: constant returned by the ID register.
- `clk` in 1: system clock, same clock as the SPI slave.
- `reset` in 1: asynchronous, active-high reset.
- `spi_address` in 8: first byte of the last completed transaction; bit 7 = write flag, bits 6:0 = register address.
- `spi_data` in 8: second byte of the last completed transaction.
- `spi_data_ready` in 1: high while chip-select is inactive; a rising edge marks the end of a transaction.
- `spi_address_ready` in 1: high during the data-byte phase of a transaction.
- `spi_data_in` out 8: read data sampled by the slave during the data-byte phase.
- `gpio_in` in `GPIO_W`: asynchronous pin inputs.
- `gpio_out` out `GPIO_W`: output values.
- `gpio_oe` out `GPIO_W`: output enables, 1 = drive.
- `commit` out 1: one-cycle pulse when a transaction is accepted.
- `irq` out 1: interrupt request, active high.

## Operation
- **Register map** (address 6:0):
  - 0x00 ID: read-only, `ID_VALUE`.
  - 0x01 OUT: read/write.
  - 0x02 DIR: read/write.
  - 0x03 IN: read-only, synchronised pins.
  - 0x04 IRQ_STAT: write-1-to-clear.
  - 0x05 IRQ_MASK: read/write.
  - 0x06 SCRATCH: read/write, 8 bits.
  - Any other address: reads 0x00, writes are ignored.
- Bits at and above `GPIO_W` read 0 and ignore writes, except in SCRATCH.
- **Transaction detect:** `dr_q` is a registered copy of `spi_data_ready`. The commit condition is `spi_data_ready & ~dr_q`.
- **On commit:**
  - Latch `spi_address[6:0]` into `rd_ptr`.
  - If `spi_address[7]` = 1, write `spi_data` to the addressed register.
  - Pulse `commit`.
  - Writes to read-only registers are dropped, but `rd_ptr` still updates.
- **Pipelined read:** the slave cannot present the current address until CS deasserts. Therefore the data byte of each transaction returns the register selected by the *previous* transaction's address.
  - Hosts issue a dummy transaction (write flag 0, address X) and then read X in the following transaction.
- `spi_data_in` is a registered output.
  - While `spi_address_ready` = 0, it is updated every cycle to the read value at `rd_ptr`.
  - While `spi_address_ready` = 1, it holds, so the byte is stable across the data phase.
- **GPIO inputs:** two-flop synchroniser, then a third flop for edge detection. A rising edge is `s2 & ~s3`.
- **Interrupts** (see Configuration):
  - A rising edge on pin i sets IRQ_STAT[i].
  - `irq` = |(IRQ_STAT & IRQ_MASK), registered.

## Timing
- **Reset values:**
  - `gpio_out`, `gpio_oe`, SCRATCH, IRQ_STAT, IRQ_MASK, `rd_ptr`, `spi_data_in`, `commit`, `irq`: all 0.
  - Synchroniser flops: 0.
  - `dr_q`: 1. This suppresses a spurious commit at reset release while CS is idle.
- **Write latency:** the commit is detected at clock edge N, where `spi_data_ready` = 1 and `dr_q` = 0.
  - The register, `gpio_out`/`gpio_oe` and `commit` are all visible after edge N.
  - `commit` is high for exactly cycle N+1.
- **Read path:** `spi_data_in` reflects a write committed at edge N after edge N+1, provided `spi_address_ready` is low.
- **GPIO edge to IRQ:** IRQ_STAT is set 3 cycles after the pin change is sampled. `irq` follows 1 cycle later.
- **Simultaneous IRQ set and W1C clear** of the same bit in one cycle: the set wins.
- **Reset mid-transaction:** all state is restored to reset values immediately and asynchronously. A partial SPI frame produces no commit unless a fresh `spi_data_ready` rising edge occurs after reset.
- **Back-to-back transactions:** each rising edge of `spi_data_ready` commits exactly once, whatever the spacing.

## Configuration
- `IO_IRQ_EN` defined:
  - IRQ_STAT, IRQ_MASK, the edge-detect flop and `irq` logic are present.
- `IO_IRQ_EN` undefined:
  - Addresses 0x04 and 0x05 read 0x00 and ignore writes.
  - `irq` is tied to 0.
  - The synchroniser keeps only its two flops.

## Structure
- **Shared package `io_extend_pkg`:**
  - Register address constants: `REG_ID`, `REG_OUT`, `REG_DIR`, `REG_IN`, `REG_IRQ_STAT`, `REG_IRQ_MASK`, `REG_SCRATCH`.
  - Write-flag bit index (7).
  - Default `ID_VALUE`.
- **Sub-module `gpio_input_sync`:** `GPIO_W`-wide two-flop synchroniser plus optional rising-edge output. Instantiated once.

## Test plan
- Reset release with `spi_data_ready` held at 1 -> no `commit` pulse, all outputs 0.
- Write transaction (`spi_address` 0x81, `spi_data` 0x3C), then a rising edge on `spi_data_ready` -> `gpio_out` = 0x3C one cycle later, one `commit` pulse.
- Read transaction to address 0x00, then a second transaction -> `spi_data_in` = 0xA5 during the second transaction's `spi_address_ready` phase.
- Change `rd_ptr`'s register while `spi_address_ready` = 1 -> `spi_data_in` is unchanged until `spi_address_ready` falls.
- With `IO_IRQ_EN`: IRQ_MASK = 0x01, then a rising edge on `gpio_in[0]` -> IRQ_STAT = 0x01 and `irq` = 1. Then write 0x84/0x01 -> `irq` = 0.
- Assert `reset` mid-frame after writing OUT = 0xFF -> `gpio_out` = 0 immediately, no commit after deassertion.
